// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings for the iterative RV32M divider
// Purpose : op encodings, op-field bit positions, FSM state type and a
//           small op-decode helper used by iter_divider.
// Ports   : none (package).
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // op[0]=1 selects the unsigned variants, op[1]=1 selects the remainder.
    localparam int DIV_OP_UNSIGNED_BIT = 0;
    localparam int DIV_OP_REM_BIT      = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[DIV_OP_UNSIGNED_BIT];
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
// Purpose : shifts the next dividend bit into the partial remainder,
//           trial-subtracts the divisor over WIDTH+1 bits and produces the
//           next partial remainder and quotient.
// Ports   : i_rem  partial remainder      i_quo  quotient/dividend shifter
//           i_dvs  divisor magnitude      o_rem  next partial remainder
//           o_quo  next quotient shifter
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    assign w_trial = {i_rem, i_quo[WIDTH-1]};
    assign w_fits  = (w_trial >= {1'b0, i_dvs});
    // Only the low WIDTH bits of the difference are kept; when the divisor
    // fits they hold the exact new remainder, so the top bit is not formed.
    assign w_diff  = w_trial[WIDTH-1:0] - i_dvs;

    assign o_rem = w_fits ? w_diff : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit
// Purpose : restoring divider, one quotient bit per cycle, valid/ready
//           handshake on both sides so the hazard unit can stall on it.
//           Optional macro DIV_SPECIAL_BYPASS_EN: divide-by-zero and signed
//           overflow skip the iterations (IDLE->FIX->DONE).
// Ports   : clk, rst_n (async, active low), flush (abort any operation)
//           in_valid/in_ready, op, dividend, divisor  - operand side
//           out_valid/out_ready, result               - result side
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       r_state;
    div_state_e       w_state_nxt;

    logic             r_rem_op;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_orig;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div0;
    logic             r_ovf;

    logic             w_accept;
    logic             w_signed;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div0;
    logic             w_ovf;
    logic             w_skip_calc;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_result_nxt;

    // ---------------------------------------------------------------- decode
    assign w_accept  = in_valid && (r_state == IDLE) && !flush;
    assign w_signed  = op_is_signed(op);
    assign w_dvd_neg = w_signed && dividend[WIDTH-1];
    assign w_dvs_neg = w_signed && divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
    assign w_div0    = (divisor == '0);
    assign w_ovf     = w_signed && (dividend == MIN_NEG) && (divisor == '1);

`ifdef DIV_SPECIAL_BYPASS_EN
    assign w_skip_calc = w_div0 || w_ovf;
`else
    assign w_skip_calc = 1'b0;
`endif

    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------- iteration
    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // ---------------------------------------------------------------- fixup
    assign w_quo_fix = r_q_neg ? -r_quo : r_quo;
    assign w_rem_fix = r_r_neg ? -r_rem : r_rem;

    // Architectural special cases are applied here so the result does not
    // depend on whether the iterations actually ran.
    always_comb begin
        w_result_nxt = r_rem_op ? w_rem_fix : w_quo_fix;
        if (r_div0) begin
            w_result_nxt = r_rem_op ? r_orig : '1;
        end else if (r_ovf) begin
            w_result_nxt = r_rem_op ? '0 : MIN_NEG;
        end
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = w_skip_calc ? FIX : CALC;
                end
            end
            CALC: begin
                if (w_last_iter) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A kill from the pipeline overrides everything, including an accept.
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem_op <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_orig   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rem_op <= op[DIV_OP_REM_BIT];
                // The quotient register starts as the dividend magnitude and
                // is shifted out MSB-first while quotient bits shift in.
                r_quo    <= w_dvd_mag;
                r_rem    <= '0;
                r_dvs    <= w_dvs_mag;
                r_orig   <= dividend;
                r_cnt    <= '0;
                r_q_neg  <= (w_dvd_neg != w_dvs_neg) && !w_div0;
                r_r_neg  <= w_dvd_neg;
                r_div0   <= w_div0;
                r_ovf    <= w_ovf;
            end else if ((r_state == CALC) && !flush) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((r_state == FIX) && !flush) begin
                r_result <= w_result_nxt;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider
module tb_iter_divider;

    localparam int W = 32;
`ifdef DIV_SPECIAL_BYPASS_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 34;
`endif
    localparam int LAT_NORMAL = 34;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics written with plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        bit is_signed;
        bit is_rem;
        int sa;
        int sb;
        is_signed = (o == 2'b00) || (o == 2'b10);
        is_rem    = (o == 2'b10) || (o == 2'b11);
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed) begin
            sa = $signed(a);
            sb = $signed(b);
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called at a falling edge. cycles counts clock cycles from the one in
    // which the operation is accepted (1) to the first with out_valid high.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cycles, output bit ok);
        int n;
        ok     = 1'b0;
        res    = '0;
        cycles = 0;
        n      = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        op       = o;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        op       = 2'($urandom_range(0, 3));
        while (!out_valid && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        if (out_valid) begin
            res = result;
            ok  = 1'b1;
        end else begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid got 0 expected 1 after %0d cycles", cycles);
        end
    endtask

    vec_t        vecs[16];
    logic [31:0] res;
    int          cyc;
    bit          ok;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          seen_valid;

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[5]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[8]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[9]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1};
        vecs[10] = '{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[11] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1};
        vecs[12] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[13] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[14] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[15] = '{2'b00, 32'd0,          32'd5,          32'd0,          1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        #3;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // flush and in_valid together in IDLE: nothing is accepted
        op = 2'b01; dividend = 32'd10; divisor = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush beats accept in_ready", 32'(in_ready), 32'd1);

        // directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, cyc, ok);
            if (ok) begin
                check($sformatf("vec%0d result", i), res, vecs[i].exp);
                check($sformatf("vec%0d latency", i), 32'(cyc),
                      32'(vecs[i].special ? LAT_SPECIAL : LAT_NORMAL));
            end
        end

        // randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(0, 20);
                1: rb = -$urandom_range(1, 20);
                2: rb = 32'd0;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            do_op(ro, ra, rb, res, cyc, ok);
            if (ok) begin
                check($sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb), res, ref_model(ro, ra, rb));
                check($sformatf("rand%0d latency", i), 32'(cyc),
                      32'(is_special(ro, ra, rb) ? LAT_SPECIAL : LAT_NORMAL));
            end
        end

        // backpressure: result held while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        do_op(2'b01, 32'd100, 32'd7, res, cyc, ok);
        if (ok) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                @(negedge clk);
                check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
                check($sformatf("hold%0d result", k), result, 32'd14);
                check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release in_ready", 32'(in_ready), 32'd1);
        check("release out_valid", 32'(out_valid), 32'd0);

        // flush at CALC iteration 10
        op = 2'b01; dividend = 32'hDEAD_BEEF; divisor = 32'd13;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("calc in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        seen_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("no out_valid after flush", 32'(seen_valid), 32'd0);

        // async reset mid-CALC
        op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-reset result held", result, 32'd14);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset result", result, 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(2'b01, 32'd9, 32'd3, res, cyc, ok);
        if (ok) begin
            check("post-reset DIVU 9/3", res, 32'd3);
            check("post-reset latency", 32'(cyc), 32'(LAT_NORMAL));
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
